// File: rtl/rtype_issue.sv
// RV32 R-type decode and issue stage: decodes instruction words, reads operands from a
// 32x32 register file, issues one operation at a time to the ALU, commits its writeback.
module rtype_issue #(
    parameter int CHECK_FUNCT7 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [2:0]  funct3,
    output logic        bit_th,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_WB
    } state_t;

    state_t      r_state;
    logic [31:0] r_rf [32];
    logic [4:0]  r_pending_rd;
    logic        r_issue_valid;
    logic [2:0]  r_funct3;
    logic        r_bit_th;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [4:0]  r_rd;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_f7_ok;
    logic        w_legal;
    logic        w_wb_match;
    logic        w_instr_ready;
    logic        w_accept;
    logic        w_take;
    logic        w_drop;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_funct3 = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_funct7 = instr[31:25];

    // With checking disabled only funct7[5] matters, so every funct7 pattern is accepted.
    assign w_f7_ok = (CHECK_FUNCT7 != 0)
                   ? ((w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))))
                   : 1'b1;
    assign w_legal = (w_opcode == 7'b0110011) && w_f7_ok;

    assign w_wb_match = wb_valid && (wb_rd == r_pending_rd);

    always_comb begin
        w_instr_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE:    w_instr_ready = 1'b1;
                S_WAIT_WB: w_instr_ready = w_wb_match;
                default:   w_instr_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = instr_valid && w_instr_ready;
    assign w_take   = w_accept && w_legal;
    assign w_drop   = w_accept && !w_legal;

    // Same-cycle writeback bypasses the register file so dependent ops issue without a bubble.
    assign w_op1 = (w_rs1 == 5'd0) ? 32'd0
                 : (wb_valid && (wb_rd == w_rs1)) ? wb_data : r_rf[w_rs1];
    assign w_op2 = (w_rs2 == 5'd0) ? 32'd0
                 : (wb_valid && (wb_rd == w_rs2)) ? wb_data : r_rf[w_rs2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pending_rd  <= 5'd0;
            r_issue_valid <= 1'b0;
            r_funct3      <= 3'd0;
            r_bit_th      <= 1'b0;
            r_in1         <= 32'd0;
            r_in2         <= 32'd0;
            r_rd          <= 5'd0;
            r_illegal     <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else begin
            r_illegal <= w_drop;

            if (wb_valid && (wb_rd != 5'd0)) begin
                r_rf[wb_rd] <= wb_data;
            end

            if (w_take) begin
                r_issue_valid <= 1'b1;
                r_funct3      <= w_funct3;
                r_bit_th      <= w_funct7[5];
                r_in1         <= w_op1;
                r_in2         <= w_op2;
                r_rd          <= w_rd;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        r_issue_valid <= 1'b0;
                        if (r_rd == 5'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_pending_rd <= r_rd;
                            r_state      <= S_WAIT_WB;
                        end
                    end
                end
                S_WAIT_WB: begin
                    if (w_wb_match) begin
                        r_state <= w_take ? S_ISSUE : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = w_instr_ready;
    assign issue_valid = r_issue_valid;
    assign funct3      = r_funct3;
    assign bit_th      = r_bit_th;
    assign in1         = r_in1;
    assign in2         = r_in2;
    assign rd          = r_rd;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_rtype_issue.sv
// Bench for rtype_issue: scoreboard of expected issued operations plus directed handshake,
// legality, forwarding and reset checks; a second instance runs with funct7 checking off.
module tb_rtype_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        issue_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;

    logic        instr_ready, issue_valid, bit_th, illegal;
    logic [2:0]  funct3;
    logic [31:0] in1, in2;
    logic [4:0]  rd;

    logic        d0_instr_ready, d0_issue_valid, d0_bit_th, d0_illegal;
    logic [2:0]  d0_funct3;
    logic [31:0] d0_in1, d0_in2;
    logic [4:0]  d0_rd;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [2:0]  f3;
        logic        th;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb [$];
    exp_t        e_mon;
    logic [31:0] m_rf [32];

    always #5 clk = ~clk;

    rtype_issue u_dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .funct3(funct3), .bit_th(bit_th), .in1(in1), .in2(in2), .rd(rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal)
    );

    rtype_issue #(.CHECK_FUNCT7(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(d0_instr_ready), .instr(instr),
        .issue_valid(d0_issue_valid), .issue_ready(issue_ready),
        .funct3(d0_funct3), .bit_th(d0_bit_th), .in1(d0_in1), .in2(d0_in2), .rd(d0_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(d0_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic legal_strict(input logic [31:0] ins);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        return (ins[6:0] == 7'h33) &&
               (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r, input logic wv,
                                              input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (wv && wr == r) return wd;
        return m_rf[r];
    endfunction

    // Present one instruction for one edge (optionally with a writeback in the same cycle).
    task automatic send(input logic [31:0] ins, input logic wv = 1'b0,
                        input logic [4:0] wr = 5'd0, input logic [31:0] wd = 32'd0);
        exp_t e;
        instr = ins; instr_valid = 1'b1;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        if (legal_strict(ins)) begin
            e.f3 = ins[14:12];
            e.th = ins[30];
            e.a  = model_read(ins[19:15], wv, wr, wd);
            e.b  = model_read(ins[24:20], wv, wr, wd);
            e.rd = ins[11:7];
            sb.push_back(e);
        end
        @(negedge clk);
        chk("acc_rdy", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        if (wv && wr != 5'd0) m_rf[wr] = wd;
        instr_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
        @(posedge clk); #1;
        if (r != 5'd0) m_rf[r] = d;
        wb_valid = 1'b0;
    endtask

    task automatic handshake();
        issue_ready = 1'b1;
        @(posedge clk); #1;
        issue_ready = 1'b0;
    endtask

    // Issue, accept immediately, then return the writeback so the stage goes back to IDLE.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] res,
                          input logic wv = 1'b0, input logic [4:0] wr = 5'd0,
                          input logic [31:0] wd = 32'd0);
        send(ins, wv, wr, wd);
        issue_ready = 1'b1;
        @(negedge clk);
        chk("iss_vld", {31'd0, issue_valid}, 32'd1);
        @(posedge clk); #1;
        issue_ready = 1'b0;
        if (ins[11:7] != 5'd0) wb_write(ins[11:7], res);
    endtask

    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_issue", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("sb_f3", {29'd0, funct3}, {29'd0, e_mon.f3});
                chk("sb_th", {31'd0, bit_th}, {31'd0, e_mon.th});
                chk("sb_in1", in1, e_mon.a);
                chk("sb_in2", in2, e_mon.b);
                chk("sb_rd", {27'd0, rd}, {27'd0, e_mon.rd});
            end
        end
    end

    initial begin
        logic [31:0] h_in1, h_in2;
        logic [4:0]  h_rd;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_rdy", {31'd0, instr_ready}, 32'd0);
        chk("rst_vld", {31'd0, issue_valid}, 32'd0);
        chk("rst_in1", in1, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", {31'd0, instr_ready}, 32'd1);
        chk("idle_ill", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;

        // Basic add, then back-pressure
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd3);
        send(32'h002081B3);
        @(negedge clk);
        chk("add_vld", {31'd0, issue_valid}, 32'd1);
        chk("add_in1", in1, 32'd5);
        chk("add_in2", in2, 32'd3);
        chk("add_rd", {27'd0, rd}, 32'd3);
        chk("add_th", {31'd0, bit_th}, 32'd0);
        h_in1 = in1; h_in2 = in2; h_rd = rd;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1'b1; instr = 32'h00118233;
            @(negedge clk);
            chk("bp_vld", {31'd0, issue_valid}, 32'd1);
            chk("bp_rdy", {31'd0, instr_ready}, 32'd0);
            chk("bp_in1", in1, h_in1);
            chk("bp_in2", in2, h_in2);
            chk("bp_rd", {27'd0, rd}, {27'd0, h_rd});
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        handshake();
        @(negedge clk);
        chk("wait_vld", {31'd0, issue_valid}, 32'd0);
        chk("wait_rdy", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;

        // Non-matching writeback in WAIT_WB: writes x5 but keeps waiting
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'd7;
        @(negedge clk);
        chk("nomatch_rdy", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        m_rf[5] = 32'd7;
        wb_valid = 1'b0;

        // Dependent instruction accepted in the writeback cycle, zero bubble
        send(32'h00118233, 1'b1, 5'd3, 32'd8);
        @(negedge clk);
        chk("b2b_vld", {31'd0, issue_valid}, 32'd1);
        chk("b2b_in1", in1, 32'd8);
        chk("b2b_in2", in2, 32'd5);
        chk("b2b_rd", {27'd0, rd}, 32'd4);
        @(posedge clk); #1;
        handshake();
        wb_write(5'd4, 32'd13);

        // sub forms
        send(32'h40128333);
        @(negedge clk);
        chk("sub_th", {31'd0, bit_th}, 32'd1);
        chk("sub_in1", in1, 32'd7);
        @(posedge clk); #1;
        handshake();
        wb_write(5'd6, 32'd2);
        run_op(32'h402081B3, 32'd2);

        // Illegal opcode and illegal funct7
        send(32'h00500093);
        @(negedge clk);
        chk("addi_ill", {31'd0, illegal}, 32'd1);
        chk("addi_vld", {31'd0, issue_valid}, 32'd0);
        chk("addi_ill_nochk", {31'd0, d0_illegal}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ill_pulse", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;
        send(32'h022081B3);
        @(negedge clk);
        chk("mul_ill", {31'd0, illegal}, 32'd1);
        chk("mul_vld", {31'd0, issue_valid}, 32'd0);
        chk("mul_nochk_ill", {31'd0, d0_illegal}, 32'd0);
        chk("mul_nochk_vld", {31'd0, d0_issue_valid}, 32'd1);
        chk("mul_nochk_th", {31'd0, d0_bit_th}, 32'd0);
        chk("mul_nochk_in1", d0_in1, m_rf[1]);
        chk("mul_nochk_in2", d0_in2, m_rf[2]);
        @(posedge clk); #1;
        handshake();
        wb_write(5'd3, 32'd9);

        // x0 handling: write discarded, forward from x0 ignored, rd=0 skips the wait
        wb_write(5'd0, 32'hFFFFFFFF);
        send(32'h001003B3);
        @(negedge clk);
        chk("x0_in1", in1, 32'd0);
        @(posedge clk); #1;
        handshake();
        wb_write(5'd7, 32'd5);
        run_op(32'h00000433, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        run_op(32'h00208033, 32'd0);
        @(negedge clk);
        chk("rd0_idle_rdy", {31'd0, instr_ready}, 32'd1);
        chk("rd0_idle_vld", {31'd0, issue_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset while in WAIT_WB
        send(32'h002081B3);
        handshake();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        chk("postrst_vld", {31'd0, issue_valid}, 32'd0);
        send(32'h002081B3);
        @(negedge clk);
        chk("postrst_in1", in1, 32'd0);
        chk("postrst_in2", in2, 32'd0);
        @(posedge clk); #1;
        handshake();
        wb_write(5'd3, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
